// File: rtl/mix_uart_pkg.sv
// Shared definitions for the MIX console UART path (receiver now, transmitter later).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mix_uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 288;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_t;

   localparam logic [5:0] MIX_SPACE  = 6'd0;
   localparam logic [5:0] MIX_LF     = 6'd10;
   localparam logic [5:0] MIX_CR     = 6'd20;
   localparam logic [5:0] MIX_BEL    = 6'd21;
   localparam logic [5:0] MIX_DIGIT0 = 6'd30;

endpackage

// File: rtl/ascii_to_mix.sv
// Maps an 8-bit ASCII byte to the 6-bit MIX character code; lowercase folds onto uppercase.
// Latency: purely combinational.
// Backpressure: none; bytes without a MIX glyph give code 0 with unmapped set.
module ascii_to_mix
   import mix_uart_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [5:0] code,
   output logic       unmapped
);

   logic [7:0] upper;

   // fold 'a'..'z' onto 'A'..'Z' so the table only lists uppercase
   always_comb begin
      upper = ascii;
      if (ascii >= 8'h61 && ascii <= 8'h7A) begin
         upper = ascii - 8'h20;
      end
   end

   // MIX table; letter runs are offset from the low six ASCII bits
   always_comb begin
      code     = MIX_SPACE;
      unmapped = 1'b0;
      case (upper) inside
         8'h20:         code = MIX_SPACE;
         [8'h41:8'h49]: code = upper[5:0];            // 'A'..'I' -> 1..9
         8'h0A:         code = MIX_LF;
         [8'h4A:8'h52]: code = upper[5:0] + 6'd1;     // 'J'..'R' -> 11..19
         8'h0D:         code = MIX_CR;
         8'h07:         code = MIX_BEL;
         [8'h53:8'h5A]: code = upper[5:0] + 6'd3;     // 'S'..'Z' -> 22..29
         [8'h30:8'h39]: code = upper[5:0] - 6'h30 + MIX_DIGIT0;
         8'h2E:         code = 6'd40;                 // .
         8'h2C:         code = 6'd41;                 // ,
         8'h28:         code = 6'd42;                 // (
         8'h29:         code = 6'd43;                 // )
         8'h2B:         code = 6'd44;                 // +
         8'h2D:         code = 6'd45;                 // -
         8'h2A:         code = 6'd46;                 // *
         8'h2F:         code = 6'd47;                 // /
         8'h3D:         code = 6'd48;                 // =
         8'h24:         code = 6'd49;                 // $
         8'h3C:         code = 6'd50;                 // <
         8'h3E:         code = 6'd51;                 // >
         8'h40:         code = 6'd52;                 // @
         8'h3B:         code = 6'd53;                 // ;
         8'h3A:         code = 6'd54;                 // :
         8'h27:         code = 6'd55;                 // '
         default: begin
            code     = MIX_SPACE;
            unmapped = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/uart_rx_mix.sv
// Receives 8N1 UART frames on rx, translates each byte to a MIX code and holds it in a one-entry buffer.
// Latency: 2 sync + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks from the rx falling edge to valid.
// Backpressure: valid/ready; a character arriving while the buffer is held full is dropped and overrun pulses.
module uart_rx_mix
   import mix_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic [5:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       code_err,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic        rx_meta;
   logic        rxs;
   rx_state_t   state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic [5:0]  dec_code;
   logic        dec_unmapped;

   // two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // decode is taken straight off the shift register; it is only used once all 8 bits are in
   ascii_to_mix u_dec (
      .ascii    (shreg),
      .code     (dec_code),
      .unmapped (dec_unmapped)
   );

   // frame FSM with baud/bit counters, shift register and the registered output buffer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
         data      <= 6'd0;
         valid     <= 1'b0;
         code_err  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (valid && ready) begin
            valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  baud_cnt <= 16'd0;
                  state    <= ST_START;
               end
            end

            ST_START: begin
               if (baud_cnt == HALF_CNT) begin
                  baud_cnt <= 16'd0;
                  if (!rxs) begin
                     bit_idx <= 3'd0;
                     state   <= ST_DATA;
                  end else begin
                     // start bit did not survive to mid-bit: line glitch
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            ST_DATA: begin
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt <= 16'd0;
                  shreg    <= {rxs, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            ST_STOP: begin
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt <= 16'd0;
                  if (rxs) begin
                     state <= ST_IDLE;
                     // a slot frees up if the consumer drains the buffer this same cycle
                     if (!valid || ready) begin
                        valid    <= 1'b1;
                        data     <= dec_code;
                        code_err <= dec_unmapped;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            ST_WAIT_IDLE: begin
               if (rxs) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_mix.sv
// Directed bench for uart_rx_mix: frames, decode, framing error, glitch, overrun and reset.
// Latency: checks first-character latency against the computed value.
// Backpressure: exercises ready=0 overrun and later drain.
module tb_uart_rx_mix;

   localparam int CPB = 288;
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rx;
   logic       ready;
   logic [5:0] data;
   logic       valid;
   logic       code_err;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [6:0] rxq[$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int vld_cnt = 0;
   int first_vld_cyc = -1;
   logic valid_q = 1'b0;

   uart_rx_mix #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .code_err  (code_err),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // observe on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (resetn) begin
         if (valid && ready) rxq.push_back({code_err, data});
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (valid) vld_cnt++;
         if (valid && !valid_q && first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      valid_q = valid;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input int exp_data, input int exp_err);
      logic [6:0] e;
      if (rxq.size() == 0) begin
         chk({tag, ".present"}, 0, 1);
      end else begin
         e = rxq.pop_front();
         chk({tag, ".data"}, int'(e[5:0]), exp_data);
         chk({tag, ".code_err"}, int'(e[6]), exp_err);
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int fall_cyc;
      int fe_base;
      int ov_base;
      int vld_base;

      rx     = 1'b1;
      ready  = 1'b1;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.valid", int'(valid), 0);
      chk("rst.data", int'(data), 0);
      chk("rst.code_err", int'(code_err), 0);
      chk("rst.frame_err", int'(frame_err), 0);
      chk("rst.overrun", int'(overrun), 0);
      resetn = 1'b1;
      idle(10);

      // good frame 'A'
      vld_base = vld_cnt;
      first_vld_cyc = -1;
      fall_cyc = cyc + 1;
      send_byte(8'h41, 1'b1);
      idle(20);
      chk("A.latency", first_vld_cyc - fall_cyc, LAT);
      chk("A.valid_cycles", vld_cnt - vld_base, 1);
      chk("A.count", rxq.size(), 1);
      pop_chk("A", 1, 0);

      // back-to-back sequence LF, 'z', '\''
      fe_base = fe_cnt;
      send_byte(8'h0A, 1'b1);
      send_byte(8'h7A, 1'b1);
      send_byte(8'h27, 1'b1);
      idle(20);
      chk("seq.count", rxq.size(), 3);
      pop_chk("seq0", 10, 0);
      pop_chk("seq1", 29, 0);
      pop_chk("seq2", 55, 0);
      chk("seq.frame_err", fe_cnt - fe_base, 0);

      // unmapped '#'
      send_byte(8'h23, 1'b1);
      idle(20);
      pop_chk("hash", 0, 1);

      // framing error, then line held low
      fe_base  = fe_cnt;
      vld_base = vld_cnt;
      send_byte(8'h55, 1'b0);
      rx = 1'b0;
      repeat (3000) @(posedge clk);
      #1;
      chk("ferr.pulses", fe_cnt - fe_base, 1);
      chk("ferr.no_valid", vld_cnt - vld_base, 0);
      idle(CPB);
      send_byte(8'h31, 1'b1);
      idle(20);
      pop_chk("after_ferr", 31, 0);

      // glitch shorter than half a bit
      fe_base  = fe_cnt;
      vld_base = vld_cnt;
      rx = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      idle(2 * CPB);
      chk("glitch.no_valid", vld_cnt - vld_base, 0);
      chk("glitch.no_ferr", fe_cnt - fe_base, 0);

      // overrun with ready held low
      ready   = 1'b0;
      ov_base = ov_cnt;
      send_byte(8'h42, 1'b1);
      send_byte(8'h43, 1'b1);
      idle(20);
      chk("ovr.valid", int'(valid), 1);
      chk("ovr.data", int'(data), 2);
      chk("ovr.pulses", ov_cnt - ov_base, 1);
      chk("ovr.no_consume", rxq.size(), 0);
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("ovr.drain_count", rxq.size(), 1);
      pop_chk("ovr.drain", 2, 0);
      chk("ovr.valid_after", int'(valid), 0);

      // reset in the middle of a frame, with a character pending
      ready = 1'b0;
      send_byte(8'h44, 1'b1);
      idle(10);
      chk("pre_rst.data", int'(data), 4);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      #3 resetn = 1'b0;
      #1;
      chk("mid_rst.valid", int'(valid), 0);
      chk("mid_rst.data", int'(data), 0);
      chk("mid_rst.frame_err", int'(frame_err), 0);
      rx    = 1'b1;
      ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      idle(5);
      send_byte(8'h5A, 1'b1);
      idle(20);
      chk("post_rst.count", rxq.size(), 1);
      pop_chk("post_rst", 29, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
